// File: rtl/accel_ball_pkg.sv
// Shared constants and fixed-point types for the tilt-driven ball.
package accel_ball_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int FRAC     = 6;
    localparam int VMAX     = 1023;
    localparam int DEADZONE = 4;

    typedef logic signed [17:0] pos_t;
    typedef logic signed [11:0] vel_t;

endpackage

// File: rtl/accel_ball_move_if.sv
// Frame strobe, tilt inputs and sprite position outputs.
interface accel_ball_move_if;

    logic              pix_stb;
    logic              screenend;
    logic signed [7:0] accel_x;
    logic signed [7:0] accel_y;
    logic [9:0]        pl_x;
    logic [9:0]        pl_y;

    modport master (
        output pix_stb, screenend, accel_x, accel_y,
        input  pl_x, pl_y
    );

    modport slave (
        input  pix_stb, screenend, accel_x, accel_y,
        output pl_x, pl_y
    );

endinterface

// File: rtl/accel_axis.sv
// One axis: deadzone, velocity saturation, semi-implicit Euler step, wall clamp.
module accel_axis
    import accel_ball_pkg::*;
#(
    parameter int START = 250,
    parameter int MAX   = 624
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic signed [7:0] i_accel,
    output logic [9:0]        o_pl
);

    localparam pos_t             P_START = pos_t'(START << FRAC);
    localparam pos_t             P_MAX   = pos_t'(MAX << FRAC);
    localparam logic signed [12:0] VLIM  = 13'(VMAX);
    localparam logic signed [7:0]  DZ    = 8'(DEADZONE);

    pos_t              r_p;
    vel_t              r_v;
    logic signed [7:0] w_a;
    logic signed [12:0] w_vsum;
    vel_t              w_v;
    pos_t              w_psum;
    pos_t              w_pn;
    vel_t              w_vn;

    always_comb begin
        w_a = i_accel;
        if ((i_accel < DZ) && (i_accel > -DZ))
            w_a = '0;

        // 13 bits so the unsaturated sum never wraps
        w_vsum = 13'(r_v) + 13'(w_a);
        if (w_vsum > VLIM)
            w_v = vel_t'(VLIM);
        else if (w_vsum < -VLIM)
            w_v = vel_t'(-VLIM);
        else
            w_v = vel_t'(w_vsum);

        w_psum = r_p + pos_t'(w_v);
        w_pn   = w_psum;
        w_vn   = w_v;
        if (w_psum < 0) begin
            w_pn = '0;
            w_vn = '0;
        end else if (w_psum > P_MAX) begin
            w_pn = P_MAX;
            w_vn = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p  <= P_START;
            r_v  <= '0;
            o_pl <= 10'(START);
        end else if (i_tick) begin
            r_p  <= w_pn;
            r_v  <= w_vn;
            o_pl <= w_pn[FRAC+9:FRAC];
        end
    end

endmodule

// File: rtl/accel_ball_move.sv
// Ball physics top: frame tick from pixel strobe, one integrator per axis.
module accel_ball_move
    import accel_ball_pkg::*;
#(
    parameter int SPRITE_PL_X = 250,
    parameter int SPRITE_PL_Y = 130,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16
) (
    input logic              CLK,
    input logic              rst,
    accel_ball_move_if.slave bus
);

    logic w_tick;

    assign w_tick = bus.pix_stb & bus.screenend;

    accel_axis #(
        .START (SPRITE_PL_X),
        .MAX   (SCREEN_W - SPRITE_W)
    ) u_x (
        .clk     (CLK),
        .rst     (rst),
        .i_tick  (w_tick),
        .i_accel (bus.accel_x),
        .o_pl    (bus.pl_x)
    );

    accel_axis #(
        .START (SPRITE_PL_Y),
        .MAX   (SCREEN_H - SPRITE_H)
    ) u_y (
        .clk     (CLK),
        .rst     (rst),
        .i_tick  (w_tick),
        .i_accel (bus.accel_y),
        .o_pl    (bus.pl_y)
    );

endmodule

// File: tb/tb_accel_ball_move.sv
// Directed bench for accel_ball_move with a behavioural physics scoreboard.
module tb_accel_ball_move;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic CLK = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    exp_t q[$];

    int mpx, mpy, mvx, mvy;
    int prev_x;

    accel_ball_move_if bif();

    accel_ball_move dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [9:0] got,
                         input logic [9:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_true(input string tag, input logic ok,
                              input int got, input int lim);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s got %0d limit %0d", tag, got, lim);
        end
    endtask

    task automatic mdl_axis(inout int p, inout int v, input int acc,
                            input int mx);
        int a;
        a = (acc > -4 && acc < 4) ? 0 : acc;
        v = v + a;
        if (v > 1023) v = 1023;
        if (v < -1023) v = -1023;
        p = p + v;
        if (p < 0) begin
            p = 0;
            v = 0;
        end else if (p > mx * 64) begin
            p = mx * 64;
            v = 0;
        end
    endtask

    task automatic step(input logic r, input logic stb, input logic se,
                        input int ax, input int ay, input string tag);
        exp_t e, got;
        @(negedge CLK);
        rst = r;
        bif.pix_stb   = stb;
        bif.screenend = se;
        bif.accel_x   = 8'(ax);
        bif.accel_y   = 8'(ay);
        if (!r) begin
            mpx = 250 * 64; mpy = 130 * 64; mvx = 0; mvy = 0;
        end else if (stb && se) begin
            mdl_axis(mpx, mvx, ax, 624);
            mdl_axis(mpy, mvy, ay, 464);
        end
        e.x = 10'(mpx / 64);
        e.y = 10'(mpy / 64);
        q.push_back(e);
        @(posedge CLK);
        #1;
        e = q.pop_front();
        got.x = bif.pl_x;
        got.y = bif.pl_y;
        check({tag, "_x"}, got.x, e.x);
        check({tag, "_y"}, got.y, e.y);
    endtask

    initial begin
        rst = 1'b0;
        bif.pix_stb = 1'b0; bif.screenend = 1'b0;
        bif.accel_x = '0;   bif.accel_y = '0;
        mpx = 0; mpy = 0; mvx = 0; mvy = 0;

        // reset held 3 cycles, with a tick present to show reset dominates
        step(0, 1, 1, 100, 100, "rst0");
        step(0, 0, 0, 0, 0, "rst1");
        step(0, 0, 0, 0, 0, "rst2");
        check("rst_const_x", bif.pl_x, 10'd250);
        check("rst_const_y", bif.pl_y, 10'd130);
        for (int i = 0; i < 4; i++)
            step(1, 0, 1, 50, -50, "idle");
        check("idle_x", bif.pl_x, 10'd250);

        // case 2: first two frames against hand-computed values
        step(1, 1, 1, -32, -120, "f1");
        check("f1_x", bif.pl_x, 10'd249);
        check("f1_y", bif.pl_y, 10'd128);
        step(1, 1, 1, -32, -120, "f2");
        check("f2_x", bif.pl_x, 10'd248);
        check("f2_y", bif.pl_y, 10'd124);

        // case 3: drive into the top/left walls
        for (int i = 0; i < 70; i++)
            step(1, 1, 1, -32, -120, "wall_lo");
        check("top_wall_y", bif.pl_y, 10'd0);
        check("left_wall_x", bif.pl_x, 10'd0);

        // case 4: full right tilt from reset
        step(0, 0, 0, 0, 0, "rst4");
        prev_x = 250;
        for (int i = 0; i < 70; i++) begin
            step(1, 1, 1, 127, 0, "right");
            check_true("mono_x", int'(bif.pl_x) >= prev_x,
                       int'(bif.pl_x), prev_x);
            check_true("vmax_x", int'(bif.pl_x) - prev_x <= 16,
                       int'(bif.pl_x) - prev_x, 16);
            prev_x = int'(bif.pl_x);
        end
        check("right_wall_x", bif.pl_x, 10'd624);
        step(1, 1, 1, 127, 127, "bot_start");
        for (int i = 0; i < 60; i++)
            step(1, 1, 1, 127, 127, "bot");
        check("bot_wall_y", bif.pl_y, 10'd464);

        // case 5: inputs inside the deadzone
        step(0, 0, 0, 0, 0, "rst5");
        for (int i = 0; i < 100; i++)
            step(1, 1, 1, 3, -3, "dz");
        check("dz_x", bif.pl_x, 10'd250);
        check("dz_y", bif.pl_y, 10'd130);

        // case 6: freeze without strobe, then reset mid-motion
        for (int i = 0; i < 5; i++)
            step(1, 1, 1, 60, 40, "move");
        for (int i = 0; i < 5; i++)
            step(1, 0, 1, 60, 40, "frz");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 60, 40, "frz2");
        step(0, 1, 1, 60, 40, "rst6");
        check("rst6_x", bif.pl_x, 10'd250);
        check("rst6_y", bif.pl_y, 10'd130);
        step(1, 1, 1, 64, 64, "restart");
        check("restart_x", bif.pl_x, 10'd251);
        check("restart_y", bif.pl_y, 10'd131);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
